wb_ram_arbiter: RTL and testbench

//  Two-master Wishbone classic arbiter in front of the single-port on-chip RAM slave.
//  M0 is the CPU data port; M1 is the instruction fetch/DMA port.

---
 rtl/wb_ram_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_ram_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the on-chip RAM slave.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin IDLE tie-break (default: M0 wins ties).
module wb_ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;   // last master served: 0 = M0, 1 = M1
  logic       tie_m1;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_m1 = ~last_q;
`else
  // Fixed priority: last_served is still tracked but never steers a tie.
  assign tie_m1 = last_q & 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = tie_m1 ? GNT1 : GNT0;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o = {state_q == GNT1, state_q == GNT0};

  // Slave mux and ack routing depend only on the registered grant, so a late
  // ack after a handoff lands on the new owner's state and is dropped for the old.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    if (gnt_o[0]) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i;
    end else if (gnt_o[1]) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboarded bench for wb_ram_arbiter with a small registered-ack RAM slave model.
module tb_wb_ram_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
  logic [1:0][3:0]  m_sel = '0;
  logic [1:0][31:0] m_adr = '0, m_dat = '0;
  logic [1:0][31:0] m_rdat;
  logic [1:0]       m_ack;
  logic             s_cyc, s_stb, s_we, s_ack;
  logic [3:0]       s_sel;
  logic [31:0]      s_adr, s_wdat, s_rdat;
  logic [1:0]       gnt;
  logic [31:0]      mem [64];

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] ex;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int nvec = 0;
  int nerr = 0;

  wb_ram_arbiter #(.AW(32), .DW(32), .SW(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  // RAM slave: one registered ack per access; word 4 (0x10) preloaded.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_rdat <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'h1234_5678 : 32'h0;
    end else begin
      s_ack <= s_cyc & s_stb & ~s_ack;
      if (s_cyc && s_stb && !s_ack) begin
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[7:2]][b*8 +: 8] <= s_wdat[b*8 +: 8];
        end else begin
          s_rdat <= mem[s_adr[7:2]];
        end
      end
    end
  end

  // Monitor: every master ack pops one expected transfer.
  always @(negedge clk) begin
    if (!rst && m_ack !== 2'b00) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL spurious_ack: got ack=%b, expected none", m_ack);
      end else begin
        e = sb.pop_front();
        if (m_ack !== (2'b01 << e.id) || (!e.we && m_rdat[e.id] !== e.ex)) begin
          nerr++;
          $display("FAIL ack_m%0d: got ack=%b data=%h, expected ack=%b data=%h",
                   e.id, m_ack, m_rdat[e.id], 2'b01 << e.id, e.ex);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    nvec++;
    if (act !== ex) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, ex);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One access by master id; cyc kept unless last/early. early drops cyc in the ack cycle.
  task automatic xfer(input int id, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic [31:0] ex, input bit last, input bit early);
    bit got;
    sb.push_back('{id: id, we: we, ex: ex});
    m_cyc[id] = 1'b1; m_stb[id] = 1'b1; m_we[id] = we;
    m_adr[id] = adr;  m_dat[id] = dat;  m_sel[id] = sel;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (m_ack[id] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL ack_timeout_m%0d: got no ack, expected ack within 20 cycles", id);
    end
    if (!early) begin @(posedge clk); #1; end
    m_stb[id] = 1'b0;
    if (last || early) m_cyc[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int w, l;
    // Async reset mid-period, before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", {30'b0, gnt}, 32'h0);
    chk("rst_s_cyc", {31'b0, s_cyc}, 32'h0);
    chk("rst_s_stb", {31'b0, s_stb}, 32'h0);
    chk("rst_acks", {30'b0, m_ack}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle(1);
    chk("idle_gnt", {30'b0, gnt}, 32'h0);

    // Simultaneous requests; loser withdraws so each round starts from a fresh tie.
    for (int r = 0; r < 3; r++) begin
      w = (RR && r == 1) ? 1 : 0;
      l = 1 - w;
      m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
      m_adr[0] = 32'h10; m_adr[1] = 32'h10; m_sel[0] = 4'hF; m_sel[1] = 4'hF;
      @(posedge clk); #1;
      chk($sformatf("tie_gnt_r%0d", r), {30'b0, gnt}, (w == 1) ? 32'h2 : 32'h1);
      m_cyc[l] = 1'b0; m_stb[l] = 1'b0;
      xfer(w, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
      idle(1);
      chk($sformatf("tie_release_r%0d", r), {30'b0, gnt}, 32'h0);
    end

    // Single M0 read of 0x10.
    fork
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        chk("m0rd_gnt", {30'b0, gnt}, 32'h1);
        chk("m0rd_adr", s_adr, 32'h10);
        chk("m0rd_stb", {31'b0, s_stb}, 32'h1);
        @(posedge clk); #1;
        chk("m0rd_ack", {30'b0, m_ack}, 32'h1);
      end
    join
    idle(2);

    // M1 burst of 4 half-word writes while M0 waits.
    fork
      for (int i = 0; i < 4; i++) begin
        xfer(1, 1'b1, 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 4'b0011, 32'h0, i == 3, 1'b0);
        if (i < 3) chk($sformatf("burst_hold_%0d", i), {30'b0, gnt}, 32'h2);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[0] = 32'h8; m_sel[0] = 4'hF;
      end
    join
    chk("burst_drop_gnt", {30'b0, gnt}, 32'h2);
    @(posedge clk); #1;
    chk("handoff_gnt", {30'b0, gnt}, 32'h1);
    chk("handoff_stb", {31'b0, s_stb}, 32'h1);
    chk("handoff_adr", s_adr, 32'h8);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'h0000_3333, 1'b1, 1'b0);
    idle(2);

    // M0 drops cyc in its ack cycle while M1 waits.
    fork
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1234_5678, 1'b1, 1'b1);
      begin
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_adr[1] = 32'h4; m_sel[1] = 4'hF;
      end
    join
    @(posedge clk); #1;
    chk("early_gnt", {30'b0, gnt}, 32'h2);
    chk("early_stb", {31'b0, s_stb}, 32'h1);
    chk("early_m1ack", {31'b0, m_ack[1]}, 32'h0);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, 32'h0000_2222, 1'b1, 1'b0);
    idle(2);

    // Reset pulse during an M1 write.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = 32'h30; m_dat[1] = 32'h5555_5555; m_sel[1] = 4'hF;
    @(posedge clk); #1;
    chk("midwr_gnt", {30'b0, gnt}, 32'h2);
    chk("midwr_cyc", {31'b0, s_cyc}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc", {31'b0, s_cyc}, 32'h0);
    chk("midrst_gnt", {30'b0, gnt}, 32'h0);
    m_cyc = '0; m_stb = '0; m_we = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(1);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle(3);

    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
